// File: rtl/decode_stage_sb.sv
// Registered, handshaked scalar decoder for the ASIP decode stage.
// A per-register load scoreboard stalls fetch on load-use and write-after-write hazards.
module decode_stage_sb #(
    parameter int N        = 16,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             MemoryWrite,
    output logic [1:0]       WriteRegFrom,
    output logic [3:0]       RegToWrite,
    output logic [3:0]       RegSrcA,
    output logic [3:0]       RegSrcB,
    output logic [7:0]       Immediate,
    output logic             RegWriteEn,
    output logic             IsLoad,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [2:0] LL = 3'(LOAD_LAT);

    logic [3:0] op, rd, rs_a, rs_b;
    logic [7:0] imm;
    logic [1:0] dec_wrf;
    logic       dec_mw, dec_rwe, dec_load;
    logic       rd_a, rd_b, hazard, accept;

    logic [2:0] sb_q [16];
    logic [2:0] sb_d [16];
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic       mw_q, rwe_q, load_q;
    logic [1:0] wrf_q;
    logic [3:0] rd_q, rs_a_q, rs_b_q;
    logic [7:0] imm_q;

    assign op   = instruction[N-1:N-4];
    assign rd   = instruction[N-5:N-8];
    assign rs_a = instruction[7:4];
    assign rs_b = instruction[3:0];
    assign imm  = instruction[7:0];

    assign dec_wrf  = (op == 4'd0) ? 2'b10 : {1'b0, ~op[3]};
    assign dec_mw   = (op == 4'b1100);
    assign dec_rwe  = ~op[0] | (op[1] & op[2]);
    assign dec_load = dec_rwe & (dec_wrf == 2'b00) & ~dec_mw;

    // LOSC reads nothing, ALU reads both sources, memory ops read only the address
    assign rd_a = (op != 4'd0);
    assign rd_b = (op != 4'd0) & ~op[3];

    assign hazard = in_valid & ((rd_a & (sb_q[rs_a] != 3'd0)) |
                                (rd_b & (sb_q[rs_b] != 3'd0)) |
                                ((dec_mw | dec_rwe) & (sb_q[rd] != 3'd0)));

    assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        sb_d = sb_q;
        if (flush) begin
            for (int r = 0; r < 16; r++) sb_d[r] = 3'd0;
        end else begin
            if (out_ready) begin
                for (int r = 0; r < 16; r++)
                    if (sb_q[r] != 3'd0) sb_d[r] = sb_q[r] - 3'd1;
            end
            if (accept && dec_load) sb_d[rd] = LL;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (accept)    out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_comb begin
        stall_d = stall_q;
        if (hazard && !flush && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 16; r++) sb_q[r] <= 3'd0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
            mw_q        <= 1'b0;
            rwe_q       <= 1'b0;
            load_q      <= 1'b0;
            wrf_q       <= 2'b00;
            rd_q        <= 4'd0;
            rs_a_q      <= 4'd0;
            rs_b_q      <= 4'd0;
            imm_q       <= 8'd0;
        end else begin
            sb_q        <= sb_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
            if (accept) begin
                mw_q   <= dec_mw;
                rwe_q  <= dec_rwe;
                load_q <= dec_load;
                wrf_q  <= dec_wrf;
                rd_q   <= rd;
                rs_a_q <= rs_a;
                rs_b_q <= rs_b;
                imm_q  <= imm;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign MemoryWrite  = mw_q;
    assign WriteRegFrom = wrf_q;
    assign RegToWrite   = rd_q;
    assign RegSrcA      = rs_a_q;
    assign RegSrcB      = rs_b_q;
    assign Immediate    = imm_q;
    assign RegWriteEn   = rwe_q;
    assign IsLoad       = load_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Directed bench for decode_stage_sb: decode fields, load-use and WAW stalls,
// back-pressure freeze, flush and asynchronous reset mid-stall.
module tb_decode_stage_sb;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [15:0] instruction;
    logic        MemoryWrite, RegWriteEn, IsLoad;
    logic [1:0]  WriteRegFrom;
    logic [3:0]  RegToWrite, RegSrcA, RegSrcB;
    logic [7:0]  Immediate;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    decode_stage_sb #(.N(16), .LOAD_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .MemoryWrite(MemoryWrite), .WriteRegFrom(WriteRegFrom),
        .RegToWrite(RegToWrite), .RegSrcA(RegSrcA), .RegSrcB(RegSrcB),
        .Immediate(Immediate), .RegWriteEn(RegWriteEn), .IsLoad(IsLoad),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins);
        in_valid    = v;
        instruction = ins;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instruction = 16'h0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step(); step();
        rst = 1'b0;

        // single LOSC decode
        drive(1'b1, 16'h03A5);
        chk("losc_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("losc_valid", 32'(out_valid), 32'd1);
        chk("losc_wrf", 32'(WriteRegFrom), 32'd2);
        chk("losc_rd", 32'(RegToWrite), 32'd3);
        chk("losc_imm", 32'(Immediate), 32'hA5);
        chk("losc_rwe", 32'(RegWriteEn), 32'd1);
        chk("losc_mw", 32'(MemoryWrite), 32'd0);
        chk("losc_isload", 32'(IsLoad), 32'd0);
        drive(1'b0, 16'h0);
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // load-use, out_ready held high
        drive(1'b1, 16'hA500);
        step();
        chk("ld_isload", 32'(IsLoad), 32'd1);
        chk("ld_wrf", 32'(WriteRegFrom), 32'd0);
        chk("ld_rd", 32'(RegToWrite), 32'd5);
        drive(1'b1, 16'h2150);
        chk("lu_stall1", 32'(in_ready), 32'd0);
        step();
        chk("lu_stall2", 32'(in_ready), 32'd0);
        step();
        chk("lu_accept", 32'(in_ready), 32'd1);
        chk("lu_count", 32'(stall_count), 32'd2);
        step();
        chk("alu_valid", 32'(out_valid), 32'd1);
        chk("alu_srca", 32'(RegSrcA), 32'd5);
        chk("alu_rd", 32'(RegToWrite), 32'd1);
        chk("alu_wrf", 32'(WriteRegFrom), 32'd1);
        chk("alu_isload", 32'(IsLoad), 32'd0);
        drive(1'b0, 16'h0);
        step();

        // back-pressure freezes outputs and scoreboard
        drive(1'b1, 16'hA500);
        step();
        out_ready = 1'b0;
        drive(1'b1, 16'h2150);
        for (int i = 0; i < 4; i++) begin
            chk("bp_stall", 32'(in_ready), 32'd0);
            chk("bp_hold_rd", 32'(RegToWrite), 32'd5);
            chk("bp_hold_ld", 32'(IsLoad), 32'd1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_adv1", 32'(in_ready), 32'd0);
        step();
        chk("bp_adv2", 32'(in_ready), 32'd0);
        step();
        chk("bp_accept", 32'(in_ready), 32'd1);
        chk("bp_count", 32'(stall_count), 32'd8);
        step();
        chk("bp_alu_srca", 32'(RegSrcA), 32'd5);
        drive(1'b0, 16'h0);
        step();

        // SUPIX reading a busy rd
        drive(1'b1, 16'hA700);
        step();
        drive(1'b1, 16'hC710);
        chk("st_stall1", 32'(in_ready), 32'd0);
        step();
        chk("st_stall2", 32'(in_ready), 32'd0);
        step();
        chk("st_accept", 32'(in_ready), 32'd1);
        step();
        chk("st_mw", 32'(MemoryWrite), 32'd1);
        chk("st_isload", 32'(IsLoad), 32'd0);
        chk("st_rwe", 32'(RegWriteEn), 32'd1);
        chk("st_count", 32'(stall_count), 32'd10);
        drive(1'b0, 16'h0);
        step();

        // flush clears scoreboard and the held instruction
        drive(1'b1, 16'hA900);
        step();
        drive(1'b1, 16'h2290);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("fl_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        #1;
        chk("fl_after_ready", 32'(in_ready), 32'd1);
        step();
        chk("fl_dep_valid", 32'(out_valid), 32'd1);
        chk("fl_dep_srca", 32'(RegSrcA), 32'd9);
        chk("fl_count", 32'(stall_count), 32'd10);
        drive(1'b0, 16'h0);
        step();

        // WAW: LOSC behind a load to the same rd stalls, to an idle rd does not
        drive(1'b1, 16'hA400);
        step();
        drive(1'b1, 16'h0411);
        chk("waw_stall", 32'(in_ready), 32'd0);
        step();
        drive(1'b1, 16'h0611);
        chk("waw_idle_ready", 32'(in_ready), 32'd1);
        step();
        chk("waw_idle_rd", 32'(RegToWrite), 32'd6);
        chk("waw_count", 32'(stall_count), 32'd11);
        drive(1'b0, 16'h0);
        step(); step();

        // asynchronous reset in the middle of a stall
        drive(1'b1, 16'hA800);
        step();
        drive(1'b1, 16'h2180);
        chk("ar_stall", 32'(in_ready), 32'd0);
        step();
        chk("ar_count_pre", 32'(stall_count), 32'd12);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_rd", 32'(RegToWrite), 32'd0);
        chk("ar_isload", 32'(IsLoad), 32'd0);
        chk("ar_wrf", 32'(WriteRegFrom), 32'd0);
        chk("ar_count", 32'(stall_count), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        #1 rst = 1'b0;
        step();
        chk("ar_post_valid", 32'(out_valid), 32'd1);
        chk("ar_post_srca", 32'(RegSrcA), 32'd8);
        chk("ar_post_count", 32'(stall_count), 32'd0);
        drive(1'b0, 16'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_sb.md
Name: decode_stage_sb

Overview:
- Registered, handshaked successor to the combinational scalar decoder in the ASIP decode stage.
- Accepts one instruction per cycle from fetch and decodes the same opcode map: LOSC, ALU ops, memory ops, SUPIX.
- Adds two fields beyond the previous decoder: source-register fields and a per-register load scoreboard, which stalls fetch on load-use and write-after-write hazards.
- Adds pipeline flush and a saturating hazard-stall counter. Sits between the fetch register and the execute stage.

Parameters:
- N, 16, instruction width; must be >= 16. Bits [N-9:8] are reserved and ignored.
- LOAD_LAT, 2, number of advancing cycles a loaded register stays busy after the load is accepted; 1..7.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  decode accepts the instruction this cycle
- instruction  in  N  instruction word
- out_valid  out  1  decoded instruction held for execute
- out_ready  in  1  execute consumes it; pipeline advances
- MemoryWrite  out  1  store (SUPIX)
- WriteRegFrom  out  2  00 memory, 01 ALU, 10 immediate
- RegToWrite  out  4  destination register rd
- RegSrcA  out  4  source register rs_a
- RegSrcB  out  4  source register rs_b
- Immediate  out  8  imm
- RegWriteEn  out  1  register write enable
- IsLoad  out  1  load: RegWriteEn & WriteRegFrom==00 & ~MemoryWrite
- stall_count  out  CNT_W  hazard-stall cycles

Behaviour:
- Field extraction:
  - op = instruction[N-1:N-4]; rd = instruction[N-5:N-8]
  - rs_a = [7:4]; rs_b = [3:0]; imm = [7:0]
- Decode rules:
  - WriteRegFrom = 2'b10 if op==0, else {1'b0, ~op[3]}
  - MemoryWrite = (op==4'b1100)
  - RegWriteEn = ~op[0] | (op[1] & op[2])
- Sources read:
  - op==0 (LOSC): reads none
  - op[3]==0, op!=0 (ALU): reads rs_a and rs_b
  - op[3]==1: reads rs_a (address)
  - SUPIX additionally reads rd (store data)
- Scoreboard:
  - 16 counters sb[r], each 3 bits.
  - hazard = in_valid & (sb[s]!=0 for any read source s, or (RegWriteEn & sb[rd]!=0)).
  - Checked against registered sb values.
- Handshake: in_ready = (~out_valid | out_ready) & ~hazard & ~flush. Accept = in_valid & in_ready.
- Accept cycle actions:
  - All decoded outputs are registered and out_valid is set to 1.
  - If the accepted instruction is a load, sb[rd] is set to LOAD_LAT, overriding any decrement of that counter in the same cycle.
- Advance (out_ready=1, no flush):
  - Every other nonzero sb decrements by 1.
  - out_valid clears if there is no accept.
- Hold: when out_valid=1 and out_ready=0, outputs and sb stay frozen; back-pressure stops the scoreboard.
- Timing example, LOAD_LAT=2, out_ready held 1:
  - Load accepted in cycle 0.
  - Dependent instruction stalls in cycles 1 and 2 and is accepted in cycle 3: exactly LOAD_LAT bubbles.
- Flush: out_valid<=0, all sb<=0, no accept that cycle. Flush has priority over accept and advance. Decoded outputs keep stale values while out_valid=0.
- stall_count:
  - Increments on cycles with in_valid & hazard & ~flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- Reset (async, any time including mid-stall):
  - out_valid=0 and all decoded outputs=0.
  - sb all 0 and stall_count=0.
  - in_ready is combinational, so it is 1 during reset only if in_valid has no hazard; since sb=0, it equals ~flush.
- A load to rd followed by a LOSC to the same rd is a WAW case and stalls. A LOSC to an idle register does not stall.

Test Plan:
- Single decode: reset, then LOSC 0x03A5 (op 0, rd 3, imm A5), out_ready=1 -> next cycle out_valid=1, WriteRegFrom=10, RegToWrite=3, Immediate=A5, RegWriteEn=1, MemoryWrite=0.
- Load-use: load with op 4'b1010, rd=5, then ALU op 4'b0010 with rs_a=5 back-to-back, LOAD_LAT=2 -> in_ready=0 for 2 cycles, stall_count=2, ALU op accepted in the 3rd cycle.
- Back-pressure: same load-use pair with out_ready=0 for 4 cycles after the load -> sb[5] frozen at 2, consumer stalls until 2 advancing cycles pass, and the load's outputs hold stable throughout.
- SUPIX 0xC710 -> MemoryWrite=1, IsLoad=0; with sb[7]!=0 it stalls (store-data read of rd).
- Flush: load rd=9 accepted, flush pulsed next cycle together with an instruction reading r9 -> out_valid=0, sb cleared, dependent accepted on the following cycle with no further stall.
- Async rst asserted mid-stall -> all outputs 0 immediately without a clock edge; after release, stall_count=0 and the first instruction is accepted with no stall.
